// File: rtl/accumulator_unit.sv
// Accumulator / execution unit for the 8-bit lab CPU.
// Masters the register file port, runs one operation at a time from the
// control unit, and implements MUL as a DATA_WIDTH-cycle shift-add loop.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | op_ready high, waiting for op_valid
// EXEC  | one cycle: single-cycle ops complete, MUL loads its datapath
// MUL   | DATA_WIDTH shift-add iterations, result written on the last

module accumulator_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            opcode,
    input  logic [ADDR_WIDTH-1:0] reg_sel,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic [ADDR_WIDTH-1:0] register_address,
    output logic                  ce,
    output logic [DATA_WIDTH-1:0] accumulator_input,
    input  logic [DATA_WIDTH-1:0] register_value,
    output logic [DATA_WIDTH-1:0] acc_out,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic                  done
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_LDR = 3'b010;
    localparam logic [2:0] OP_STR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              opcode_q, opcode_d;
    logic [ADDR_WIDTH-1:0]   reg_sel_q, reg_sel_d;
    logic [DATA_WIDTH-1:0]   imm_q, imm_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic                    zero_q, zero_d;
    logic                    carry_q, carry_d;
    logic                    done_q, done_d;
    logic [PW-1:0]           mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]           prod_q, prod_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic [DATA_WIDTH:0]     sum;
    logic [DATA_WIDTH:0]     diff;
    logic [PW-1:0]           prod_next;

    // ALU results; the extra top bit of diff is the borrow
    assign sum       = {1'b0, acc_q} + {1'b0, register_value};
    assign diff      = {1'b0, acc_q} - {1'b0, register_value};
    assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

    assign op_ready          = (state_q == ST_IDLE);
    assign register_address  = reg_sel_q;
    assign ce                = (state_q == ST_EXEC) && (opcode_q == OP_STR);
    assign accumulator_input = acc_q;
    assign acc_out           = acc_q;
    assign zero_flag         = zero_q;
    assign carry_flag        = carry_q;
    assign done              = done_q;

    // Next-state and datapath update for the IDLE/EXEC/MUL sequencer
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        reg_sel_d = reg_sel_q;
        imm_d    = imm_q;
        acc_d    = acc_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    opcode_d  = opcode;
                    reg_sel_d = reg_sel;
                    imm_d     = imm;
                    state_d   = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                case (opcode_q)
                    OP_LDI: begin
                        acc_d  = imm_q;
                        zero_d = (imm_q == '0);
                    end
                    OP_LDR: begin
                        acc_d  = register_value;
                        zero_d = (register_value == '0);
                    end
                    OP_ADD: begin
                        acc_d   = sum[DATA_WIDTH-1:0];
                        carry_d = sum[DATA_WIDTH];
                        zero_d  = (sum[DATA_WIDTH-1:0] == '0);
                    end
                    OP_SUB: begin
                        acc_d   = diff[DATA_WIDTH-1:0];
                        carry_d = diff[DATA_WIDTH];
                        zero_d  = (diff[DATA_WIDTH-1:0] == '0);
                    end
                    OP_AND: begin
                        acc_d   = acc_q & register_value;
                        carry_d = 1'b0;
                        zero_d  = ((acc_q & register_value) == '0);
                    end
                    OP_MUL: begin
                        mcand_d  = {{DATA_WIDTH{1'b0}}, register_value};
                        mplier_d = acc_q;
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                        done_d   = 1'b0;
                    end
                    default: begin
                        // NOP and STR leave acc and flags alone
                    end
                endcase
            end

            ST_MUL: begin
                prod_d   = prod_next;
                mcand_d  = {mcand_q[PW-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[DATA_WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    acc_d   = prod_next[DATA_WIDTH-1:0];
                    carry_d = |prod_next[PW-1:DATA_WIDTH];
                    zero_d  = (prod_next[DATA_WIDTH-1:0] == '0);
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset also aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            reg_sel_q <= '0;
            imm_q     <= '0;
            acc_q     <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            done_q    <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            reg_sel_q <= reg_sel_d;
            imm_q     <= imm_d;
            acc_q     <= acc_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            done_q    <= done_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
